// File: rtl/hazard_forward_unit.sv
// Purpose : execute-side RAW hazard resolution for the 5-stage pipeline (stall + operand forwarding).
// Latency : all outputs are combinational from the EX/MEM/WB tags and the decode inputs; tags advance every edge.
// Backpressure: stall holds PC and IF/DE and injects DE/EX bubbles; downstream stages never freeze.
//
// Ports:
//   clk, rst_n             pipeline clock, asynchronous active-low reset
//   dec_ir, dec_valid      instruction in IF/DE and its valid flag (0 = bubble)
//   flush                  taken branch/jump resolved in EX; kills dec_ir and cancels any stall
//   pc_write, dec_reg_en   PC / IF/DE load enables (low while stalled)
//   ex_bubble              load a bubble into DE/EX instead of the decoded instruction
//   stall                  hazard stall active
//   fwd_a_sel, fwd_b_sel   EX operand source: 00 regfile, 01 MEM result, 10 WB result
//
// Build option: FORWARD_EN. Defined -> forwarding plus a LOAD_LAT-bubble load-use stall.
// Undefined -> pure interlock: selects tied to 00, stall while a source is produced in EX or MEM.

`default_nettype none

module hazard_forward_unit #(
    parameter int LOAD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dec_ir,
    input  logic        dec_valid,
    input  logic        flush,
    output logic        pc_write,
    output logic        dec_reg_en,
    output logic        ex_bubble,
    output logic        stall,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Destination tag carried by every stage.
    typedef struct packed {
        logic       vld;
        logic       wr;
        logic       is_load;
        logic [4:0] rd;
    } tag_t;

    // EX additionally keeps its sources so forwarding can be resolved there.
    typedef struct packed {
        tag_t       dst;
        logic       use1;
        logic       use2;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ex_tag_t;

    function automatic ex_tag_t decode(input logic [31:0] ir, input logic vld);
        ex_tag_t t;
        t         = '0;
        t.dst.vld = vld;
        t.dst.rd  = ir[11:7];
        t.rs1     = ir[19:15];
        t.rs2     = ir[24:20];
        case (ir[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                t.dst.wr = 1'b1;
            end
            OPC_JALR, OPC_OPIMM: begin
                t.dst.wr = 1'b1;
                t.use1   = 1'b1;
            end
            OPC_LOAD: begin
                t.dst.wr      = 1'b1;
                t.dst.is_load = 1'b1;
                t.use1        = 1'b1;
            end
            OPC_OP: begin
                t.dst.wr = 1'b1;
                t.use1   = 1'b1;
                t.use2   = 1'b1;
            end
            OPC_BRANCH, OPC_STORE: begin
                t.use1 = 1'b1;
                t.use2 = 1'b1;
            end
            default: ;
        endcase
        return t;
    endfunction

    // A producer satisfies a consumer source only if it really writes a non-x0 register.
    function automatic logic src_hit(input tag_t p, input logic [4:0] rs, input logic used);
        return p.vld && p.wr && (p.rd != 5'd0) && (p.rd == rs) && used;
    endfunction

    ex_tag_t ex_tag;
    tag_t    mem_tag;
    tag_t    wb_tag;
    ex_tag_t dec_tag;

    assign dec_tag = decode(dec_ir, dec_valid);

    // Only opcode and register fields matter here.
    logic unused_ir;
    assign unused_ir = ^{dec_ir[31:25], dec_ir[14:12]};

    assign pc_write   = !stall;
    assign dec_reg_en = !stall;
    assign ex_bubble  = stall || flush || !dec_valid;

    // Tags always advance: on a flush the EX instruction still moves on so a
    // JAL/JALR keeps its link register write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_tag  <= '0;
            mem_tag <= '0;
            wb_tag  <= '0;
        end else begin
            wb_tag  <= mem_tag;
            mem_tag <= ex_tag.dst;
            ex_tag  <= ex_bubble ? '0 : dec_tag;
        end
    end

`ifdef FORWARD_EN
    localparam logic [1:0] CNT_INIT = 2'(LOAD_LAT - 1);

    logic [1:0] cnt;
    logic       ld_hzd;

    function automatic logic [1:0] fwd_sel(input ex_tag_t ex, input logic [4:0] rs,
                                           input logic used, input tag_t mem, input tag_t wb);
        if (!ex.dst.vld)               return 2'b00;
        if (src_hit(mem, rs, used))    return 2'b01;  // youngest producer wins
        if (src_hit(wb, rs, used))     return 2'b10;
        return 2'b00;
    endfunction

    // Only a load in EX needs a stall; everything else is covered by forwarding.
    assign ld_hzd = dec_tag.dst.vld && ex_tag.dst.is_load &&
                    (src_hit(ex_tag.dst, dec_tag.rs1, dec_tag.use1) ||
                     src_hit(ex_tag.dst, dec_tag.rs2, dec_tag.use2));

    assign stall = !flush && (ld_hzd || (cnt != 2'd0));

    // First bubble comes from the hazard itself, the counter supplies the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 2'd0;
        end else if (flush) begin
            cnt <= 2'd0;
        end else if (ld_hzd && (cnt == 2'd0)) begin
            cnt <= CNT_INIT;
        end else if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
        end
    end

    // A load in MEM never matches a live consumer: the stall keeps the consumer
    // out of EX until the load is in WB (LOAD_LAT=1) or retired (regfile is write-first).
    assign fwd_a_sel = fwd_sel(ex_tag, ex_tag.rs1, ex_tag.use1, mem_tag, wb_tag);
    assign fwd_b_sel = fwd_sel(ex_tag, ex_tag.rs2, ex_tag.use2, mem_tag, wb_tag);

    logic unused_tags;
    assign unused_tags = ^{mem_tag.is_load, wb_tag.is_load};
`else
    logic raw_hzd;

    // Without forwarding any producer still in EX or MEM blocks decode; WB is
    // covered by the write-first regfile.
    assign raw_hzd = dec_tag.dst.vld &&
                     (src_hit(ex_tag.dst, dec_tag.rs1, dec_tag.use1) ||
                      src_hit(ex_tag.dst, dec_tag.rs2, dec_tag.use2) ||
                      src_hit(mem_tag,    dec_tag.rs1, dec_tag.use1) ||
                      src_hit(mem_tag,    dec_tag.rs2, dec_tag.use2));

    assign stall     = !flush && raw_hzd;
    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;

    logic [1:0] unused_lat;
    logic       unused_tags;
    assign unused_lat  = 2'(LOAD_LAT);
    assign unused_tags = ^{ex_tag.rs1, ex_tag.rs2, ex_tag.use1, ex_tag.use2,
                           ex_tag.dst.is_load, mem_tag.is_load, wb_tag};
`endif

endmodule

`default_nettype wire
